// File: rtl/fetch_unit_if.sv
//------------------------------------------------------------------------------
// fetch_unit_if
// Bus bundle between the fetch unit and its surroundings: hazard/EX control
// inputs, the synchronous instruction-memory port and the IF/ID bundle.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            stall;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_instr;
  logic            if_valid;
  logic            if_misalign;

  // Fetch unit side
  modport master (
    input  stall, redirect, redirect_pc, imem_rdata,
    output imem_addr, if_pc, if_instr, if_valid, if_misalign
  );

  // Environment side (hazard unit, EX, instruction memory, IF/ID register)
  modport slave (
    output stall, redirect, redirect_pc, imem_rdata,
    input  imem_addr, if_pc, if_instr, if_valid, if_misalign
  );
endinterface

`default_nettype wire

// File: rtl/fetch_unit.sv
//------------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch front end: owns the PC, drives a 1-cycle synchronous
// instruction memory and presents {pc, instr, valid} to IF/ID. Supports
// stalls (with an instruction skid register) and redirects from EX.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fetch_unit #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);

  // fetch_pc_q is the address currently presented to memory; if_pc_q is the
  // address whose instruction sits on the output bundle.
  logic [XLEN-1:0] fetch_pc_q,   fetch_pc_d;
  logic [XLEN-1:0] if_pc_q,      if_pc_d;
  logic            valid_q,      valid_d;
  logic            hold_vld_q,   hold_vld_d;
  logic [XLEN-1:0] hold_instr_q, hold_instr_d;
  logic            misalign_q,   misalign_d;
  logic [XLEN-1:0] redirect_aligned;

  // Next-state selection: redirect beats stall beats normal sequential fetch
  always_comb begin
    redirect_aligned = {bus.redirect_pc[XLEN-1:2], 2'b00};
    fetch_pc_d       = fetch_pc_q;
    if_pc_d          = if_pc_q;
    valid_d          = valid_q;
    hold_vld_d       = hold_vld_q;
    hold_instr_d     = hold_instr_q;
    misalign_d       = 1'b0;

    if (bus.redirect) begin
      // Kill whatever is in flight; the target is fetched this cycle and
      // appears as a valid bundle one edge later.
      fetch_pc_d = redirect_aligned;
      if_pc_d    = redirect_aligned;
      valid_d    = 1'b0;
      hold_vld_d = 1'b0;
      misalign_d = |bus.redirect_pc[1:0];
    end else if (bus.stall) begin
      // Memory output moves on to fetch_pc during the stall, so capture the
      // instruction belonging to if_pc once, on the first stalled edge.
      if (!hold_vld_q) begin
        hold_instr_d = bus.imem_rdata;
        hold_vld_d   = 1'b1;
      end
    end else begin
      fetch_pc_d = fetch_pc_q + XLEN'(4);
      if_pc_d    = fetch_pc_q;
      valid_d    = 1'b1;
      hold_vld_d = 1'b0;
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q   <= RESET_PC;
      if_pc_q      <= RESET_PC;
      valid_q      <= 1'b0;
      hold_vld_q   <= 1'b0;
      hold_instr_q <= NOP_INSTR;
      misalign_q   <= 1'b0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      if_pc_q      <= if_pc_d;
      valid_q      <= valid_d;
      hold_vld_q   <= hold_vld_d;
      hold_instr_q <= hold_instr_d;
      misalign_q   <= misalign_d;
    end
  end

  assign bus.imem_addr   = fetch_pc_q;
  assign bus.if_pc       = if_pc_q;
  assign bus.if_valid    = valid_q;
  assign bus.if_misalign = misalign_q;
  assign bus.if_instr    = !valid_q   ? NOP_INSTR    :
                           hold_vld_q ? hold_instr_q : bus.imem_rdata;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
//------------------------------------------------------------------------------
// tb_fetch_unit
// Self-checking bench for fetch_unit: directed scenarios with literal
// expectations plus randomized stall/redirect traffic against a program-order
// reference model.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fetch_unit;

  localparam logic [31:0] C_MEM_KEY = 32'hA5A5_0000;
  localparam logic [31:0] C_NOP     = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  fetch_unit_if #(.XLEN(32)) bus ();

  fetch_unit #(
    .XLEN(32), .RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0013)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Instruction memory: registered read, content derived from the address
  always @(posedge clk) bus.imem_rdata <= bus.imem_addr ^ C_MEM_KEY;

  // Reference model in program-order terms: the PC of the bundle on the
  // output, whether it is valid, and whether the last edge was a misaligned
  // redirect. A valid bundle always carries mem(pc); fetch runs one ahead.
  logic [31:0] m_pc    = 32'h0;
  logic        m_valid = 1'b0;
  logic        m_mis   = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc    <= 32'h0;
      m_valid <= 1'b0;
      m_mis   <= 1'b0;
    end else if (bus.redirect) begin
      m_pc    <= bus.redirect_pc & 32'hFFFF_FFFC;
      m_valid <= 1'b0;
      m_mis   <= (bus.redirect_pc % 4) != 0;
    end else if (bus.stall) begin
      m_mis   <= 1'b0;
    end else begin
      if (m_valid) m_pc <= m_pc + 32'd4;
      m_valid <= 1'b1;
      m_mis   <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every cycle, mid-period, DUT outputs vs model
  bit cmp_en = 1'b0;
  always @(negedge clk) begin
    if (cmp_en) begin
      check("m_valid",    {31'b0, bus.if_valid},    {31'b0, m_valid});
      check("m_pc",       bus.if_pc,                m_pc);
      check("m_instr",    bus.if_instr,             m_valid ? (m_pc ^ C_MEM_KEY) : C_NOP);
      check("m_addr",     bus.imem_addr,            m_valid ? m_pc + 32'd4 : m_pc);
      check("m_misalign", {31'b0, bus.if_misalign}, {31'b0, m_mis});
    end
  end

  // Apply inputs for the next edge, then land just after that edge
  task automatic tick(input logic st, input logic rd, input logic [31:0] rpc);
    bus.stall       = st;
    bus.redirect    = rd;
    bus.redirect_pc = rpc;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_bundle(input string name, input logic v, input logic [31:0] pc,
                               input logic [31:0] ins);
    check({name, ".valid"}, {31'b0, bus.if_valid}, {31'b0, v});
    check({name, ".pc"},    bus.if_pc,             pc);
    check({name, ".instr"}, bus.if_instr,          ins);
  endtask

  task automatic expect_reset(input string name);
    expect_bundle(name, 1'b0, 32'h0, C_NOP);
    check({name, ".addr"},     bus.imem_addr,            32'h0);
    check({name, ".misalign"}, {31'b0, bus.if_misalign}, 32'h0);
  endtask

  initial begin
    bus.stall       = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;

    // 1: reset for two cycles, then sequential fetch from 0
    repeat (2) @(posedge clk);
    #1;
    expect_reset("rst");
    rst    = 1'b0;
    cmp_en = 1'b1;
    tick(0, 0, 0); expect_bundle("t1a", 1, 32'h0, 32'hA5A5_0000);
    tick(0, 0, 0); expect_bundle("t1b", 1, 32'h4, 32'hA5A5_0004);
    tick(0, 0, 0); expect_bundle("t1c", 1, 32'h8, 32'hA5A5_0008);

    // 2: stall three cycles holding pc 8, then resume without skip/duplicate
    for (int i = 0; i < 3; i++) begin
      tick(1, 0, 0); expect_bundle("t2hold", 1, 32'h8, 32'hA5A5_0008);
    end
    tick(0, 0, 0); expect_bundle("t2rel", 1, 32'hC,  32'hA5A5_000C);
    tick(0, 0, 0); expect_bundle("t2nx",  1, 32'h10, 32'hA5A5_0010);

    // 3: redirect to 0x100 -> one bubble, then target stream
    tick(0, 1, 32'h100); expect_bundle("t3bub", 0, 32'h100, C_NOP);
    tick(0, 0, 0);       expect_bundle("t3a",   1, 32'h100, 32'hA5A5_0100);
    tick(0, 0, 0);       expect_bundle("t3b",   1, 32'h104, 32'hA5A5_0104);

    // 4: redirect wins over stall; misaligned redirect pulses if_misalign
    tick(1, 1, 32'h200); expect_bundle("t4bub", 0, 32'h200, C_NOP);
    tick(1, 0, 0);       expect_bundle("t4stl", 0, 32'h200, C_NOP);
    tick(0, 0, 0);       expect_bundle("t4a",   1, 32'h200, 32'hA5A5_0200);
    tick(0, 1, 32'h302);
    check("t4mis1", {31'b0, bus.if_misalign}, 32'h1);
    check("t4pc",   bus.if_pc, 32'h300);
    tick(0, 0, 0);
    check("t4mis0", {31'b0, bus.if_misalign}, 32'h0);
    expect_bundle("t4b", 1, 32'h300, 32'hA5A5_0300);

    // 5: PC wraps past the top of the address space
    tick(0, 1, 32'hFFFF_FFF8);
    tick(0, 0, 0); expect_bundle("t5a", 1, 32'hFFFF_FFF8, 32'h5A5A_FFF8);
    tick(0, 0, 0); expect_bundle("t5b", 1, 32'hFFFF_FFFC, 32'h5A5A_FFFC);
    tick(0, 0, 0); expect_bundle("t5c", 1, 32'h0000_0000, 32'hA5A5_0000);

    // 6: asynchronous reset mid-stall takes effect between edges
    tick(1, 0, 0);
    tick(1, 0, 0);
    #3 rst = 1'b1;
    #1 expect_reset("t6rst");
    @(posedge clk);
    #1 rst = 1'b0;
    tick(0, 0, 0); expect_bundle("t6a", 1, 32'h0, 32'hA5A5_0000);
    tick(0, 0, 0); expect_bundle("t6b", 1, 32'h4, 32'hA5A5_0004);

    // Randomized traffic checked by the model every cycle
    for (int i = 0; i < 600; i++) begin
      logic        st, rd;
      logic [31:0] rpc;
      st  = ($urandom_range(0, 3) == 0);
      rd  = ($urandom_range(0, 7) == 0);
      rpc = (i % 50 == 7) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      tick(st, rd, rpc);
      if (i == 300) begin
        #2 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
      end
    end

    tick(0, 0, 0);
    @(negedge clk);
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
